// File: rtl/nios_onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for nios_onchip_memory_dp: one instance per port (s1, s2).
interface nios_onchip_memory_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios_onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, pipelined reads and a post-reset clear sweep.
// Define NIOS_ONCHIP_MEM_OUTREG_EN for an extra read output register (read latency 2 instead of 1).
module nios_onchip_memory_dp #(
    parameter int                 DATA_WIDTH     = 32,
    parameter int                 ADDR_WIDTH     = 9,
    parameter bit                 CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clken,
    input  logic                   reset_req,
    output logic                   busy,
    nios_onchip_memory_dp_if.slave s1,
    nios_onchip_memory_dp_if.slave s2
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    busy_q, busy_d;
    logic                    clr_we;
    logic                    stall;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Index 0 is s1, index 1 is s2.
    logic [1:0]              wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0]   addr  [2];
    logic [BE_W-1:0]         be    [2];
    logic [DATA_WIDTH-1:0]   wdata [2];

    logic [DATA_WIDTH-1:0]   ram_p0 [2];
    logic [1:0]              vld_p0_q;
    logic [DATA_WIDTH-1:0]   rdata_p1_q [2], rdata_p1_d [2];
    logic [1:0]              vld_p1_q;
`ifdef NIOS_ONCHIP_MEM_OUTREG_EN
    logic [DATA_WIDTH-1:0]   rdata_p2_q [2], rdata_p2_d [2];
    logic [1:0]              vld_p2_q;
`endif

    assign stall = busy_q | ~clken | reset_req;
    assign busy  = busy_q;

    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;

    // A simultaneous read+write is a write only, so read acceptance excludes write.
    assign wr_acc[0] = s1.chipselect & s1.write & ~stall;
    assign wr_acc[1] = s2.chipselect & s2.write & ~stall;
    assign rd_acc[0] = s1.chipselect & s1.read & ~s1.write & ~stall;
    assign rd_acc[1] = s2.chipselect & s2.read & ~s2.write & ~stall;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            ptr_q   <= '0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // s2 lanes are applied before s1 lanes so s1 wins any lane both enable; reads see pre-edge data.
    always_ff @(posedge clk) begin
        if (clr_we) mem[ptr_q] <= CLEAR_VALUE;
        for (int p = 1; p >= 0; p--) begin
            if (wr_acc[p]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be[p][b]) mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (rd_acc[p]) ram_p0[p] <= mem[addr[p]];
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_p1_d[p] = vld_p0_q[p] ? ram_p0[p] : rdata_p1_q[p];
`ifdef NIOS_ONCHIP_MEM_OUTREG_EN
            rdata_p2_d[p] = vld_p1_q[p] ? rdata_p1_q[p] : rdata_p2_q[p];
`endif
        end
    end

    // Read pipeline: p0 = RAM output, p1 = output register, p2 = optional extra stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0_q <= '0;
            vld_p1_q <= '0;
            for (int p = 0; p < 2; p++) rdata_p1_q[p] <= '0;
`ifdef NIOS_ONCHIP_MEM_OUTREG_EN
            vld_p2_q <= '0;
            for (int p = 0; p < 2; p++) rdata_p2_q[p] <= '0;
`endif
        end else begin
            vld_p0_q <= rd_acc;
            vld_p1_q <= vld_p0_q;
            for (int p = 0; p < 2; p++) rdata_p1_q[p] <= rdata_p1_d[p];
`ifdef NIOS_ONCHIP_MEM_OUTREG_EN
            vld_p2_q <= vld_p1_q;
            for (int p = 0; p < 2; p++) rdata_p2_q[p] <= rdata_p2_d[p];
`endif
        end
    end

    assign s1.waitrequest = stall;
    assign s2.waitrequest = stall;
`ifdef NIOS_ONCHIP_MEM_OUTREG_EN
    assign s1.readdata      = rdata_p2_q[0];
    assign s2.readdata      = rdata_p2_q[1];
    assign s1.readdatavalid = vld_p2_q[0];
    assign s2.readdatavalid = vld_p2_q[1];
`else
    assign s1.readdata      = rdata_p1_q[0];
    assign s2.readdata      = rdata_p1_q[1];
    assign s1.readdatavalid = vld_p1_q[0];
    assign s2.readdatavalid = vld_p1_q[1];
`endif
endmodule

// File: tb/tb_nios_onchip_memory_dp.sv
// Directed, table-driven bench for nios_onchip_memory_dp (32x512, clear value A5A5A5A5).
module tb_nios_onchip_memory_dp;
`ifdef NIOS_ONCHIP_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset_n, clken, reset_req, busy;
    int   checks = 0;
    int   failures = 0;

    nios_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) s1_if ();
    nios_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) s2_if ();

    nios_onchip_memory_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'hA5A5A5A5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .busy(busy),
        .s1(s1_if.slave), .s2(s2_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int          port;
        bit          is_wr;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_port(int p, logic cs, logic rd, logic wr, logic [8:0] a,
                            logic [3:0] b, logic [31:0] d);
        if (p == 0) begin
            s1_if.chipselect = cs; s1_if.read = rd; s1_if.write = wr;
            s1_if.address = a; s1_if.byteenable = b; s1_if.writedata = d;
        end else begin
            s2_if.chipselect = cs; s2_if.read = rd; s2_if.write = wr;
            s2_if.address = a; s2_if.byteenable = b; s2_if.writedata = d;
        end
    endtask

    function automatic logic get_rdv(int p);
        return (p == 0) ? s1_if.readdatavalid : s2_if.readdatavalid;
    endfunction

    function automatic logic [31:0] get_rd(int p);
        return (p == 0) ? s1_if.readdata : s2_if.readdata;
    endfunction

    task automatic idle_all();
        set_port(0, 0, 0, 0, '0, '0, '0);
        set_port(1, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic do_write(int p, logic [8:0] a, logic [3:0] b, logic [31:0] d);
        set_port(p, 1, 0, 1, a, b, d);
        @(posedge clk); #1;
        set_port(p, 0, 0, 0, '0, '0, '0);
    endtask

    // Wait (bounded) for readdatavalid on port p; k = edges elapsed since the accept edge.
    task automatic wait_rdv(int p, output int k);
        k = 0;
        while (!get_rdv(p) && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic do_read(int p, logic [8:0] a, logic [31:0] exp, string nm);
        int k;
        set_port(p, 1, 1, 0, a, '0, '0);
        @(posedge clk); #1;
        set_port(p, 0, 0, 0, '0, '0, '0);
        wait_rdv(p, k);
        check({nm, "_latency"}, 64'(k), 64'(LAT));
        check(nm, 64'(get_rd(p)), 64'(exp));
        @(posedge clk); #1;
        check({nm, "_pulse_width"}, 64'(get_rdv(p)), 64'd0);
    endtask

    task automatic gated_read(bit use_clken, string nm);
        int pulses;
        if (use_clken) clken = 1'b0; else reset_req = 1'b1;
        set_port(0, 1, 1, 0, 9'd7, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({nm, "_wait"}, 64'(s1_if.waitrequest), 64'd1);
            check({nm, "_no_rdv"}, 64'(s1_if.readdatavalid), 64'd0);
        end
        clken = 1'b1; reset_req = 1'b0;
        @(posedge clk); #1;
        set_port(0, 0, 0, 0, '0, '0, '0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (s1_if.readdatavalid) begin
                pulses++;
                check({nm, "_data"}, 64'(s1_if.readdata), 64'h11FF33FF);
            end
            @(posedge clk); #1;
        end
        check({nm, "_pulses"}, 64'(pulses), 64'd1);
    endtask

    initial begin
        int          n, k, pulses;
        logic [8:0]  b2b_addr [4];
        logic [31:0] b2b_exp  [4];

        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_s1_rdv", 64'(s1_if.readdatavalid), 64'd0);
        check("rst_s2_rdv", 64'(s2_if.readdatavalid), 64'd0);
        check("rst_s1_rdata", 64'(s1_if.readdata), 64'd0);
        check("rst_s2_rdata", 64'(s2_if.readdata), 64'd0);
        check("rst_wait", 64'(s1_if.waitrequest), 64'd1);

        // Abort a sweep after 100 cycles, then time a complete one.
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("mid_sweep_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (n == 256) check("sweep_wait", 64'(s2_if.waitrequest), 64'd1);
        end
        check("sweep_cycles", 64'(n), 64'd512);
        check("ready_s1_wait", 64'(s1_if.waitrequest), 64'd0);
        check("ready_s2_wait", 64'(s2_if.waitrequest), 64'd0);

        vecs.push_back('{0, 1'b0, 9'd0,   4'h0, 32'hA5A5A5A5, "clr_addr0"});
        vecs.push_back('{1, 1'b0, 9'd255, 4'h0, 32'hA5A5A5A5, "clr_addr255"});
        vecs.push_back('{0, 1'b0, 9'd511, 4'h0, 32'hA5A5A5A5, "clr_addr511"});
        vecs.push_back('{0, 1'b1, 9'd7,   4'hF, 32'h11223344, "wr7_full"});
        vecs.push_back('{0, 1'b1, 9'd7,   4'h5, 32'hFFFFFFFF, "wr7_be0101"});
        vecs.push_back('{1, 1'b0, 9'd7,   4'h0, 32'h11FF33FF, "rd7_be_merge"});
        vecs.push_back('{1, 1'b1, 9'd20,  4'hF, 32'hDEADBEEF, "wr20_full"});
        vecs.push_back('{1, 1'b1, 9'd20,  4'h0, 32'h12345678, "wr20_be0"});
        vecs.push_back('{0, 1'b0, 9'd20,  4'h0, 32'hDEADBEEF, "rd20_be0_noop"});
        vecs.push_back('{0, 1'b1, 9'd21,  4'hA, 32'hCAFEF00D, "wr21_be1010"});
        vecs.push_back('{1, 1'b0, 9'd21,  4'h0, 32'hCAA5F0A5, "rd21_be_merge"});

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) do_write(vecs[i].port, vecs[i].addr, vecs[i].be, vecs[i].data);
            else do_read(vecs[i].port, vecs[i].addr, vecs[i].data, vecs[i].name);
        end

        // Same-address write collision: s1 owns lane 0, s2 fills the rest.
        set_port(0, 1, 0, 1, 9'd3, 4'h1, 32'h000000AA);
        set_port(1, 1, 0, 1, 9'd3, 4'hF, 32'hBBBBBBBB);
        @(posedge clk); #1;
        idle_all();
        do_read(0, 9'd3, 32'hBBBBBBAA, "collision");

        // Mixed-port read-during-write returns old data.
        do_write(1, 9'd9, 4'hF, 32'd1);
        set_port(0, 1, 1, 0, 9'd9, 4'h0, 32'd0);
        set_port(1, 1, 0, 1, 9'd9, 4'hF, 32'd2);
        @(posedge clk); #1;
        idle_all();
        wait_rdv(0, k);
        check("rdw_latency", 64'(k), 64'(LAT));
        check("rdw_old", 64'(s1_if.readdata), 64'd1);
        @(posedge clk); #1;
        do_read(0, 9'd9, 32'd2, "rdw_new");

        // read and write asserted together act as a write with no read strobe.
        set_port(0, 1, 1, 1, 9'd30, 4'hF, 32'h55);
        @(posedge clk); #1;
        idle_all();
        pulses = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            if (s1_if.readdatavalid) pulses++;
            @(posedge clk); #1;
        end
        check("rw_no_rdv", 64'(pulses), 64'd0);
        do_read(1, 9'd30, 32'h55, "rw_written");

        gated_read(1'b1, "gate_clken");
        gated_read(1'b0, "gate_reset_req");

        // Back-to-back reads: one result per cycle, LAT edges after each accept.
        b2b_addr[0] = 9'd7;  b2b_exp[0] = 32'h11FF33FF;
        b2b_addr[1] = 9'd20; b2b_exp[1] = 32'hDEADBEEF;
        b2b_addr[2] = 9'd21; b2b_exp[2] = 32'hCAA5F0A5;
        b2b_addr[3] = 9'd3;  b2b_exp[3] = 32'hBBBBBBAA;
        set_port(0, 1, 1, 0, b2b_addr[0], '0, '0);
        for (int j = 0; j < LAT + 6; j++) begin
            @(posedge clk); #1;
            if (j + 1 < 4) set_port(0, 1, 1, 0, b2b_addr[j+1], '0, '0);
            else set_port(0, 0, 0, 0, '0, '0, '0);
            check($sformatf("b2b_rdv_%0d", j), 64'(s1_if.readdatavalid),
                  64'((j >= LAT) && (j < LAT + 4)));
            if (j >= LAT && j < LAT + 4)
                check($sformatf("b2b_data_%0d", j - LAT), 64'(s1_if.readdata), 64'(b2b_exp[j-LAT]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nios_onchip_memory_dp.md
Name: nios_onchip_memory_dp

Overview:
Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2), the successor to the single-port 32x512 Nios memory.
- Adds configurable width and depth, pipelined reads with readdatavalid, waitrequest back-pressure and a post-reset hardware clear sweep.
- Sits on the Nios data master (s1) and a DMA/peripheral master (s2) as a shared scratch/mailbox buffer.
- RAM is inferred behaviourally; no vendor macro.

Parameters:
DATA_WIDTH, 32, word width; multiple of 8 (8..128).
ADDR_WIDTH, 9, word address width; depth = 2**ADDR_WIDTH.
CLEAR_ON_RESET, 1, 1 = sweep all words to CLEAR_VALUE after reset; 0 = contents undefined, ready immediately.
CLEAR_VALUE, 0, DATA_WIDTH-bit fill value for the sweep.

Ports:
clk  in  1  single clock for both ports.
reset_n  in  1  asynchronous, active-low reset.
clken  in  1  global clock enable; low blocks new transfers.
reset_req  in  1  high blocks new transfers (same role as reset_req on the existing memory).
busy  out  1  high while the clear sweep runs.
s1_address / s2_address  in  ADDR_WIDTH  word address.
s1_chipselect / s2_chipselect  in  1  select.
s1_read / s2_read  in  1  read request.
s1_write / s2_write  in  1  write request.
s1_byteenable / s2_byteenable  in  DATA_WIDTH/8  byte lanes for writes.
s1_writedata / s2_writedata  in  DATA_WIDTH  write data.
s1_waitrequest / s2_waitrequest  out  1  stall.
s1_readdata / s2_readdata  out  DATA_WIDTH  read data.
s1_readdatavalid / s2_readdatavalid  out  1  one-cycle read-data strobe.

Behaviour:
- Reset (reset_n low, async):
  - readdatavalid, readdata = 0 on both ports.
  - busy = CLEAR_ON_RESET; clear pointer = 0.
  - FSM enters CLEAR (CLEAR_ON_RESET=1) or READY.
- FSM:
  - CLEAR: writes CLEAR_VALUE to address ptr each cycle, ptr++.
  - At ptr = DEPTH-1 the write completes, then CLEAR -> READY next cycle.
  - Sweep takes exactly DEPTH cycles after reset release; it ignores clken and reset_req.
  - READY: normal operation; stays there until reset.
  - Reset mid-sweep restarts the sweep at address 0.
- sN_waitrequest = busy | ~clken | reset_req. Transfers are never accepted while waitrequest is high.
- Accept: chipselect & (read|write) & ~waitrequest at a rising edge.
  - write & read together is treated as a write only; no readdatavalid.
- Write: enabled byte lanes are updated at the accept edge; other lanes are unchanged. byteenable = 0 is a legal no-op write.
- Read latency 1: read accepted at edge N -> readdata valid with readdatavalid = 1 for exactly one cycle after edge N+1.
  - readdata holds its last value when readdatavalid = 0.
  - Back-to-back reads give one result per cycle.
- Read pipeline always advances; clken and reset_req only gate acceptance, never in-flight data.
- Same-port read-during-write: impossible, since it is a write only.
- Mixed-port read-during-write (s1 reads address X while s2 writes X in the same cycle): the read returns OLD data.
- Write/write collision on the same address in the same cycle: s1 wins on every byte lane s1 enables; s2 lanes not enabled by s1 are written.
- Address wrap: none; address is exactly ADDR_WIDTH bits.

Optional Feature:
NIOS_ONCHIP_MEM_OUTREG_EN
- Defined: an extra output register stage; read latency = 2 (readdatavalid after edge N+2); throughput still one read per cycle per port.
- Undefined: latency 1 as above.
- Collision and reset rules are identical in both builds; the extra stage resets to 0.

Test Plan:
- Clear sweep: CLEAR_ON_RESET=1, CLEAR_VALUE=32'hA5A5A5A5, release reset -> busy and waitrequest high for 512 cycles, then low; reads of addresses 0, 255 and 511 return A5A5A5A5.
- Byte enables: s1 writes 32'h11223344 to addr 7 with be=4'b1111, then 32'hFFFFFFFF with be=4'b0101; s2 reads addr 7 -> 32'h11FF33FF, readdatavalid one cycle after acceptance.
- Collision: s1 writes 32'h000000AA (be=0001) and s2 writes 32'hBBBBBBBB (be=1111) to addr 3 in the same cycle -> addr 3 reads 32'hBBBBBBAA.
- Mixed read-during-write: addr 9 = 1; s1 reads 9 while s2 writes 2 to 9 -> s1 gets 1; a following read gets 2.
- Gating: clken=0 for 3 cycles with s1_read held high -> waitrequest high, no readdatavalid; clken=1 -> exactly one readdatavalid. Repeat with reset_req=1: same result.
- Reset mid-sweep: assert reset_n=0 at sweep cycle 100, release -> busy held for a full 512 cycles again; with NIOS_ONCHIP_MEM_OUTREG_EN defined, back-to-back reads of 4 addresses give 4 consecutive readdatavalid pulses starting 2 cycles after the first acceptance.
